switch_allocator: RTL and testbench

- Round-robin switch allocator for one router.
- Arbitrates NUM_PORTS input buffer units competing for NUM_PORTS output ports.
- Locks each granted input-to-output path for a whole packet, until the input signals the tail flit.
- Drives per-input grants, which feed each buffer unit's req/grant allocator interface, and the crossbar select matrix.

---
 rtl/switch_allocator_if.sv | 20 ++
 rtl/switch_allocator.sv | 105 ++++++++++
 tb/tb_switch_allocator.sv | 123 ++++++++++++
 3 files changed

// File: rtl/switch_allocator_if.sv
// rtl/switch_allocator_if.sv - request/grant/crossbar bundle between buffer units and the switch allocator
interface switch_allocator_if #(
  parameter int N = 5
);
  logic [N*N-1:0] req;
  logic [N-1:0]   pkt_release;
  logic [N-1:0]   grant;
  logic [N*N-1:0] xbar_sel;
  logic [N-1:0]   out_busy;

  modport master (
    output req, pkt_release,
    input  grant, xbar_sel, out_busy
  );

  modport slave (
    input  req, pkt_release,
    output grant, xbar_sel, out_busy
  );
endinterface

// File: rtl/switch_allocator.sv
// rtl/switch_allocator.sv - per-output round-robin allocator that locks input-to-output paths for whole packets
module switch_allocator #(
  parameter int NUM_PORTS = 5
) (
  input  logic           clk,
  input  logic           rst,
  switch_allocator_if.slave sa
);
  localparam int N  = NUM_PORTS;
  localparam int PW = $clog2(N);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} out_state_t;

  out_state_t    state     [N];
  out_state_t    state_nxt [N];
  logic [PW-1:0] owner     [N];
  logic [PW-1:0] owner_nxt [N];
  logic [PW-1:0] ptr       [N];
  logic [PW-1:0] ptr_nxt   [N];

  logic [N-1:0]  held;
  logic [N-1:0]  low_req [N];
  logic [N-1:0]  elig    [N];
  logic [PW-1:0] win     [N];
  logic [N-1:0]  has_req;

  always_comb begin
    held = '0;
    for (int o = 0; o < N; o++) begin
      if (state[o] == LOCKED) held[owner[o]] = 1'b1;
    end
  end

  // Lowest set bit of each input's row; inputs that already own an output are silenced.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      low_req[i] = sa.req[i*N +: N] & (-sa.req[i*N +: N]);
      if (held[i]) low_req[i] = '0;
    end
    for (int o = 0; o < N; o++) begin
      elig[o] = '0;
      for (int i = 0; i < N; i++) elig[o][i] = low_req[i][o];
    end
  end

  // Descending scan with overwrite leaves the first requester at or after ptr.
  always_comb begin
    for (int o = 0; o < N; o++) begin
      win[o]     = ptr[o];
      has_req[o] = |elig[o];
      for (int k = N - 1; k >= 0; k--) begin
        if (elig[o][(int'(ptr[o]) + k) % N]) win[o] = PW'((int'(ptr[o]) + k) % N);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < N; o++) begin
        state[o] <= IDLE;
        owner[o] <= '0;
        ptr[o]   <= '0;
      end
    end else begin
      for (int o = 0; o < N; o++) begin
        state[o] <= state_nxt[o];
        owner[o] <= owner_nxt[o];
        ptr[o]   <= ptr_nxt[o];
      end
    end
  end

  always_comb begin
    for (int o = 0; o < N; o++) begin
      state_nxt[o] = state[o];
      owner_nxt[o] = owner[o];
      ptr_nxt[o]   = ptr[o];
      case (state[o])
        IDLE: begin
          if (has_req[o]) begin
            state_nxt[o] = LOCKED;
            owner_nxt[o] = win[o];
            ptr_nxt[o]   = PW'((int'(win[o]) + 1) % N);
          end
        end
        LOCKED: begin
          if (sa.pkt_release[owner[o]]) state_nxt[o] = IDLE;
        end
        default: state_nxt[o] = IDLE;
      endcase
    end
  end

  always_comb begin
    sa.xbar_sel = '0;
    sa.out_busy = '0;
    sa.grant    = held;
    for (int o = 0; o < N; o++) begin
      if (state[o] == LOCKED) begin
        sa.xbar_sel[int'(owner[o])*N + o] = 1'b1;
        sa.out_busy[o]                    = 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_switch_allocator.sv
// tb/tb_switch_allocator.sv - directed self-checking bench for switch_allocator
module tb_switch_allocator;
  localparam int N = 5;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  int   ord [4] = '{0, 1, 4, 0};

  switch_allocator_if #(.N(N)) sa ();

  switch_allocator #(.NUM_PORTS(N)) dut (
    .clk (clk),
    .rst (rst),
    .sa  (sa.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [31:0] g, input logic [31:0] x, input logic [31:0] b);
    chk({tag, ".grant"}, 32'(sa.grant), g);
    chk({tag, ".xbar"}, 32'(sa.xbar_sel), x);
    chk({tag, ".busy"}, 32'(sa.out_busy), b);
  endtask

  initial begin
    rst            = 1'b1;
    sa.req         = '1;
    sa.pkt_release = '0;

    tick();
    chk3("rst0", 0, 0, 0);
    tick();
    chk3("rst1", 0, 0, 0);
    rst    = 1'b0;
    sa.req = '0;
    tick();
    chk3("post_rst", 0, 0, 0);

    // input 2 -> output 3
    sa.req = 25'(1) << 13;
    tick();
    chk3("single_t1", 32'b00100, 32'(1) << 13, 32'b01000);
    sa.req = '0;
    tick();
    tick();
    chk3("single_t3", 32'b00100, 32'(1) << 13, 32'b01000);
    sa.pkt_release = 5'b00100;
    tick();
    sa.pkt_release = '0;
    chk3("single_rel", 0, 0, 0);

    // inputs 0, 1, 4 contend for output 1
    sa.req = (25'(1) << 1) | (25'(1) << 6) | (25'(1) << 21);
    tick();
    for (int k = 0; k < 4; k++) begin
      chk3($sformatf("rr%0d_win", k), 32'(1) << ord[k], 32'(1) << (ord[k]*N + 1), 32'b00010);
      tick();
      tick();
      chk($sformatf("rr%0d_hold", k), 32'(sa.grant), 32'(1) << ord[k]);
      sa.pkt_release = 5'(1) << ord[k];
      tick();
      sa.pkt_release = '0;
      chk3($sformatf("rr%0d_bubble", k), 0, 0, 0);
      if (k == 3) sa.req = '0;
      tick();
    end
    chk3("rr_done", 0, 0, 0);

    // 0->2, 3->2, 1->4 at the same edge
    sa.req = (25'(1) << 2) | (25'(1) << 17) | (25'(1) << 9);
    tick();
    chk3("par", 32'b00011, (32'(1) << 2) | (32'(1) << 9), 32'b10100);

    sa.req         = (25'(1) << 17) | (25'(1) << 9);
    sa.pkt_release = 5'b00100;
    tick();
    sa.pkt_release = '0;
    chk3("lock_hold", 32'b00011, (32'(1) << 2) | (32'(1) << 9), 32'b10100);
    tick();
    chk3("lock_hold2", 32'b00011, (32'(1) << 2) | (32'(1) << 9), 32'b10100);

    sa.req         = 25'(1) << 17;
    sa.pkt_release = 5'b00011;
    tick();
    sa.pkt_release = '0;
    chk3("par_rel", 0, 0, 0);
    tick();
    chk3("par_next", 32'b01000, 32'(1) << 17, 32'b00100);

    // input 1 asks for outputs 0 and 3 at once
    sa.req = (25'(1) << 5) | (25'(1) << 8);
    tick();
    chk3("multi", 32'b01010, (32'(1) << 17) | (32'(1) << 5), 32'b00101);

    rst = 1'b1;
    sa.pkt_release = 5'b01000;
    tick();
    sa.pkt_release = '0;
    chk3("mid_rst", 0, 0, 0);
    rst    = 1'b0;
    sa.req = (25'(1) << 13) | (25'(1) << 23);
    tick();
    chk3("ptr_after_rst", 32'b00100, 32'(1) << 13, 32'b01000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
